// File: rtl/div_share_arbiter.sv
// ============================================================================
// div_share_arbiter
// Round-robin sharing of one SRT divider among NREQ valid/ready requesters.
// Optional build macro: DIV_ARB_TIMEOUT_EN (RUN-state watchdog, rsp_err).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_share_arbiter #(
    parameter int N       = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4*N+8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_signed,
    input  logic [NREQ*N-1:0] req_x,
    input  logic [NREQ*N-1:0] req_y,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [N-1:0]      rsp_q,
    output logic [N-1:0]      rsp_r,
    output logic              rsp_dbz,
    output logic              rsp_err,
    output logic              div_rst,
    output logic              div_start,
    output logic              div_signed,
    output logic [N-1:0]      div_x,
    output logic [N-1:0]      div_y,
    input  logic [N-1:0]      div_q,
    input  logic [N-1:0]      div_r,
    input  logic              div_done,
    input  logic              div_dbz
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("div_share_arbiter: NREQ must be 2..8 and TIMEOUT positive");
    end

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [N-1:0]    x_q, x_d, y_q, y_d;
    logic            sgn_q, sgn_d;
    logic [N-1:0]    q_q, q_d, r_q, r_d;
    logic            dbz_q, dbz_d;
    logic            w_any;
    logic [PW-1:0]   w_gnt;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Scan from farthest to nearest offset so the nearest valid requester after rr_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req_valid[(int'(rr_ptr_q) + i) % NREQ]) begin
                w_any = 1'b1;
                w_gnt = PW'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        x_d       = x_q;
        y_d       = y_q;
        sgn_d     = sgn_q;
        q_d       = q_q;
        r_d       = r_q;
        dbz_d     = dbz_q;
        req_ready = '0;
        rsp_valid = '0;
        div_rst   = rst;
        div_start = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    req_ready = ONE << w_gnt;
                    x_d       = req_x[int'(w_gnt)*N +: N];
                    y_d       = req_y[int'(w_gnt)*N +: N];
                    sgn_d     = req_signed[w_gnt];
                    gnt_d     = w_gnt;
                    rr_ptr_d  = w_gnt;
                    state_d   = CLR;
                end
            end
            CLR: begin
                div_rst = 1'b1;
                state_d = RUN;
`ifdef DIV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            RUN: begin
                div_start = 1'b1;
                if (div_done) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    dbz_d   = div_dbz;
                    state_d = RESP;
`ifdef DIV_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    // Abandon the hung divider; the next CLR cycle recovers it.
                    q_d     = '0;
                    r_d     = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                rsp_valid = ONE << gnt_q;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
            rsp_valid = '0;
            div_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= PW'(NREQ-1);
            gnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sgn_q    <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
            dbz_q    <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sgn_q    <= sgn_d;
            q_q      <= q_d;
            r_q      <= r_d;
            dbz_q    <= dbz_d;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign div_x      = x_q;
    assign div_y      = y_q;
    assign div_signed = sgn_q;
    assign rsp_q      = q_q;
    assign rsp_r      = r_q;
    assign rsp_dbz    = dbz_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
// ============================================================================
// tb_div_share_arbiter
// Directed bench for div_share_arbiter with a small stand-in divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_share_arbiter;

    localparam int N       = 8;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 4*N+8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_signed = '0;
    logic [NREQ*N-1:0] req_x = '0;
    logic [NREQ*N-1:0] req_y = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [N-1:0]      rsp_q, rsp_r;
    logic              rsp_dbz, rsp_err;
    logic              div_rst, div_start, div_signed;
    logic [N-1:0]      div_x, div_y;
    logic [N-1:0]      div_q = '0;
    logic [N-1:0]      div_r = '0;
    logic              div_done = 1'b0;
    logic              div_dbz = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic hold_done = 1'b0;
    int   stub_cnt = 0;

    div_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
        .div_rst(div_rst), .div_start(div_start), .div_signed(div_signed),
        .div_x(div_x), .div_y(div_y), .div_q(div_q), .div_r(div_r),
        .div_done(div_done), .div_dbz(div_dbz)
    );

    always #5 clk = ~clk;

    // Stand-in divider: floor-style signed results, y=0 gives q=all ones, r=x, dbz=1.
    function automatic logic [2*N:0] stub_div(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        int sx, sy, qt, rt;
        if (y == '0) return {1'b1, {N{1'b1}}, x};
        if (s) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        qt = sx / sy;
        rt = sx % sy;
        if (rt != 0 && ((rt < 0) != (sy < 0))) begin
            qt = qt - 1;
            rt = rt + sy;
        end
        return {1'b0, qt[N-1:0], rt[N-1:0]};
    endfunction

    always @(posedge clk) begin
        if (div_rst) begin
            stub_cnt <= 0;
            div_done <= 1'b0;
        end else if (!div_start) begin
            div_done <= 1'b0;
        end else if (!div_done && !hold_done) begin
            if (stub_cnt == 3) begin
                div_done <= 1'b1;
                {div_dbz, div_q, div_r} <= stub_div(div_signed, div_x, div_y);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int exp_cycles, input string tag);
        int c;
        c = 0;
        while (rsp_valid == '0 && c < 200) begin
            tick();
            c++;
        end
        check(tag, 32'(c), 32'(exp_cycles));
    endtask

    task automatic set_req(input int k, input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        req_signed[k]    = s;
        req_x[k*N +: N]  = x;
        req_y[k*N +: N]  = y;
    endtask

    task automatic txn(input int k, input logic s, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
        set_req(k, s, x, y);
        req_valid[k] = 1'b1;
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(1 << k));
        tick();
        req_valid[k] = 1'b0;
        set_req(k, ~s, ~x, ~y);
        check("clr_div_rst", 32'(div_rst), 32'd1);
        check("clr_div_start", 32'(div_start), 32'd0);
        check("clr_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("run_div_start", 32'(div_start), 32'd1);
        check("run_div_rst", 32'(div_rst), 32'd0);
        check("run_div_x", 32'(div_x), 32'(x));
        check("run_div_y", 32'(div_y), 32'(y));
        check("run_div_signed", 32'(div_signed), 32'(s));
        wait_rsp(5, "latency");
        check("rsp_valid", 32'(rsp_valid), 32'(1 << k));
        check("rsp_q", 32'(rsp_q), 32'(eq));
        check("rsp_r", 32'(rsp_r), 32'(er));
        check("rsp_dbz", 32'(rsp_dbz), 32'(edbz));
        check("rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
        check("rsp_released", 32'(rsp_valid), 32'd0);
        check("idle_div_start", 32'(div_start), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        check("rst_div_rst", 32'(div_rst), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_rst_off", 32'(div_rst), 32'd0);
        check("rst_rsp_q", 32'(rsp_q), 32'd0);
        check("rst_div_x", 32'(div_x), 32'd0);

        // Basic transactions
        txn(0, 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        txn(1, 1'b1, 8'hF9, 8'd2, 8'hFC, 8'h01, 1'b0);
        txn(0, 1'b0, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1);

        // Reset three cycles into RUN; last grant was 0, so only reset restores priority to 0
        hold_done = 1'b1;
        set_req(0, 1'b0, 8'd100, 8'd7);
        req_valid = 2'b01;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'd1);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("pre_rst_running", 32'(div_start), 32'd1);
        set_req(1, 1'b1, 8'hF9, 8'd2);
        req_valid = 2'b11;
        rst = 1'b1;
        tick();
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_div_start", 32'(div_start), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_div_rst", 32'(div_rst), 32'd1);
        check("mid_rst_div_x", 32'(div_x), 32'd0);
        check("mid_rst_rsp_q", 32'(rsp_q), 32'd0);
        check("mid_rst_rsp_dbz", 32'(rsp_dbz), 32'd0);
        rst = 1'b0;
        hold_done = 1'b0;
        #1;
        check("post_rst_priority", 32'(req_ready), 32'd1);

        // Both requesters continuously valid: 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            int k;
            k = i % 2;
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << k));
            tick();
            tick();
            wait_rsp(5, "rr_latency");
            check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << k));
            check("rr_rsp_q", 32'(rsp_q), (k == 0) ? 32'd14 : 32'hFC);
            rsp_ready = rsp_valid;
            tick();
            rsp_ready = '0;
        end

        // Response backpressure: requester 0 stalls 10 cycles, requester 1 waits
        #1;
        check("stall_grant0", 32'(req_ready), 32'd1);
        tick();
        tick();
        wait_rsp(5, "stall_latency");
        rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_q", 32'(rsp_q), 32'd14);
            check("stall_rsp_r", 32'(rsp_r), 32'd2);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        check("grant1_after_ack", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        tick();
        wait_rsp(5, "g1_latency");
        check("g1_rsp_valid", 32'(rsp_valid), 32'd2);
        check("g1_rsp_r", 32'(rsp_r), 32'd1);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = '0;

`ifdef DIV_ARB_TIMEOUT_EN
        // Hung divider: watchdog returns an error response
        hold_done = 1'b1;
        set_req(0, 1'b0, 8'd100, 8'd7);
        req_valid = 2'b01;
        #1;
        check("to_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        tick();
        wait_rsp(TIMEOUT, "to_latency");
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_q", 32'(rsp_q), 32'd0);
        check("to_rsp_r", 32'(rsp_r), 32'd0);
        check("to_rsp_dbz", 32'(rsp_dbz), 32'd0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        hold_done = 1'b0;
        txn(1, 1'b1, 8'hF9, 8'd2, 8'hFC, 8'h01, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one SRT integer divider among NREQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one division in flight at a time.
- The controller sequences the divider's clear/start/done protocol and returns the quotient, remainder and divide-by-zero flag to the requester that was granted.

Parameters:
- N, 8, operand/result width (same as the divider's N).
- NREQ, 2, number of requesters, 2..8.
- TIMEOUT, 4*N+8, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept, one-hot or zero
- req_signed  in  NREQ  per-requester signed-operation select
- req_x  in  NREQ*N  dividends, requester k in bits [k*N +: N]
- req_y  in  NREQ*N  divisors, same packing as req_x
- rsp_valid  out  NREQ  response valid, one-hot or zero
- rsp_ready  in  NREQ  per-requester response accept
- rsp_q  out  N  quotient for the requester whose rsp_valid is high
- rsp_r  out  N  remainder
- rsp_dbz  out  1  divide-by-zero flag
- rsp_err  out  1  timeout abort flag (0 unless the optional feature is compiled in)
- div_rst  out  1  divider synchronous clear
- div_start  out  1  divider start, held until done
- div_signed  out  1  to divider signedInput
- div_x  out  N  to divider x
- div_y  out  N  to divider y
- div_q  in  N  divider q
- div_r  in  N  divider r
- div_done  in  1  divider done
- div_dbz  in  1  divider divByZeroEx

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-operation:
  - state=IDLE; rr_ptr=NREQ-1, so requester 0 has first priority.
  - All outputs 0 and all operand/result registers 0.
  - div_rst=1 is driven during reset so the divider is cleared together with the controller.
- FSM, one transition per cycle:
  - IDLE: if any req_valid, grant g = first set req_valid scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
    - req_ready[g]=1 combinationally in this cycle only.
    - Latch req_x[g], req_y[g], req_signed[g] and g into registers; rr_ptr<=g; go to CLR.
    - With no req_valid: stay in IDLE, req_ready=0.
  - CLR: div_rst=1, div_start=0 for exactly one cycle; go to RUN.
  - RUN: div_start=1; div_x/div_y/div_signed come from the latched registers and are stable throughout.
    - On div_done=1: capture div_q, div_r, div_dbz into the result registers; go to RESP.
  - RESP: rsp_valid[g]=1; rsp_q/rsp_r/rsp_dbz are driven from the result registers.
    - Stay in RESP until rsp_ready[g]=1, then go to IDLE.
    - rsp_ready of other requesters is ignored.
- Outside RUN, div_start=0. Outside CLR and reset, div_rst=0.
- Latency: request accept at cycle T, CLR at T+1, start at T+2, divider done at D, rsp_valid at D+1.
- Back-to-back: the next grant is taken in the IDLE cycle after the response handshake, so there is one idle bubble per transaction.
- Fairness: a requester holding req_valid waits at most NREQ-1 transactions.
- A requester may change its operands or drop req_valid before being granted with no effect. After the grant, its inputs are not sampled again.
- Arithmetic is fully owned by the divider; q/r pass through unmodified, with signed remainder semantics as the divider defines them.
- rsp_q/rsp_r/rsp_dbz hold their last value outside RESP.
- rsp_dbz is passed through from the divider; a y=0 request still completes normally through RESP.

Optional Feature:
- Macro DIV_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT without div_done, go to RESP with rsp_err=1, rsp_q=0, rsp_r=0, rsp_dbz=0.
  - The divider is cleared by the next transaction's CLR cycle.
- Not defined: no counter; RUN waits indefinitely; rsp_err is tied to 0.

Test Plan:
- N=8, requester 0: unsigned x=100, y=7.
  - Required: req_ready[0] pulses one cycle, div_rst for one cycle, then div_start until done.
  - Response: rsp_valid[0], q=14, r=2, dbz=0.
- Requester 1: signed x=-7 (0xF9), y=2.
  - Response: rsp_valid[1], q=0xFC (-4), r=0x01, dbz=0.
- Requester 0: unsigned x=55, y=0 -> rsp_valid[0], rsp_dbz=1, rsp_err=0.
- Both requesters valid continuously, 4 transactions, after reset.
  - Grant order must be 0, 1, 0, 1.
  - Each response goes to the matching requester index, one-hot.
- rsp_ready[0] held low 10 cycles in RESP with req_valid[1]=1.
  - rsp_valid[0] and data stay stable; req_ready[1]=0 throughout.
  - Grant to 1 occurs in the IDLE cycle after rsp_ready[0]=1.
- rst asserted 3 cycles into RUN.
  - Next cycle: all outputs 0 and state IDLE; after release, requester 0 gets priority.
  - With DIV_ARB_TIMEOUT_EN: hold div_done=0 -> rsp_err=1 exactly TIMEOUT cycles after entry to RUN.
